// File: rtl/alu_seq_pkg.sv
// Shared widths and FSM state encoding for the ALU command sequencer.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: NUM_REGS x DATA_W flops, one write port,
// three combinational read ports (two operand ports and a debug port).
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [RW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;

    // Next-state of the array: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ra_data  = mem_q[ra_addr];
    assign rb_data  = mem_q[rb_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of a registered ALU: accepts load-immediate
// and ALU-op commands, issues registered operands/select to the ALU, waits
// out its latency and writes the result back into the register file.
module alu_cmd_seq
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ALU_LAT  = 1,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ld,
    input  logic [SEL_W-1:0]  cmd_op,
    input  logic [RW-1:0]     cmd_ra,
    input  logic [RW-1:0]     cmd_rb,
    input  logic [RW-1:0]     cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              done,
    output logic [DATA_W-1:0] res_data,
    input  logic [RW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Counter only has to hold ALU_LAT-1; keep at least one bit.
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] res_q, res_d;

    logic              rf_we;
    logic [RW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] ra_data, rb_data;

    alu_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_addr  (cmd_ra),
        .ra_data  (ra_data),
        .rb_addr  (cmd_rb),
        .rb_data  (rb_data),
        .dbg_addr (rd_addr),
        .dbg_data (rd_data)
    );

    assign cmd_ready = (state_q == IDLE);

    // Next-state, issue and writeback decisions for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        done_d    = 1'b0;
        res_d     = res_q;
        rf_we     = 1'b0;
        rf_waddr  = cmd_rd;
        rf_wdata  = cmd_imm;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ld) begin
                        // Loads retire in place; issue registers untouched.
                        rf_we  = 1'b1;
                        done_d = 1'b1;
                        res_d  = cmd_imm;
                    end else begin
                        alu_a_d   = ra_data;
                        alu_b_d   = rb_data;
                        alu_sel_d = cmd_op;
                        rd_d      = cmd_rd;
                        cnt_d     = CW'(ALU_LAT - 1);
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WB: begin
                // ALU output has settled; commit it and free the front end.
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = alu_out;
                res_d    = alu_out;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, issue and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            done_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            done_q    <= done_d;
            res_q     <= res_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign done     = done_q;
    assign res_data = res_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a registered single-cycle ALU model.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_ld;
    logic [3:0] cmd_op;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd, rd_addr;
    logic [7:0] cmd_imm, alu_a, alu_b, alu_out, res_data, rd_data;
    logic [3:0] alu_sel;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_cmd_seq #(.NUM_REGS(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .done(done), .res_data(res_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // ALU behaviour: 0 add, 1 sub, others arbitrary but fixed.
    function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] s);
        case (s)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            default: return a + b + {4'h0, s};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= 8'h00;
        else        alu_out <= alu_fn(alu_a, alu_b, alu_sel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       ld;
        logic [3:0] op;
        logic [1:0] ra, rb, rd;
        logic [7:0] imm;
        logic [7:0] exp_res;
        logic [7:0] exp_a, exp_b;
        logic [3:0] exp_sel;
    } vec_t;

    // Issue one command, wait for its retire, check results and latency.
    task automatic run_cmd(input vec_t v);
        int t;
        int lat;
        int ready_low;
        @(negedge clk);
        cmd_ld = v.ld; cmd_op = v.op; cmd_ra = v.ra; cmd_rb = v.rb;
        cmd_rd = v.rd; cmd_imm = v.imm; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
        chk("accept_timeout", 32'(t < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; ready_low = 0;
        while (!done && lat < 10) begin
            if (!cmd_ready) ready_low++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), v.ld ? 32'd1 : 32'd3);
        chk("ready_low", 32'(ready_low), v.ld ? 32'd0 : 32'd2);
        chk("res_data", 32'(res_data), 32'(v.exp_res));
        rd_addr = v.rd; #1;
        chk("rd_data", 32'(rd_data), 32'(v.exp_res));
        chk("alu_a", 32'(alu_a), 32'(v.exp_a));
        chk("alu_b", 32'(alu_b), 32'(v.exp_b));
        chk("alu_sel", 32'(alu_sel), 32'(v.exp_sel));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int k, dn, bad_done;
        logic hs;

        // ld op ra rb rd imm  res  a    b    sel
        vecs[0] = '{1'b0, 4'h0, 2'd0, 2'd1, 2'd2, 8'h00, 8'hD1, 8'hB1, 8'h20, 4'h0};
        vecs[1] = '{1'b1, 4'h7, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 8'hB1, 8'h20, 4'h0};
        vecs[2] = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 8'h02, 8'h02, 8'hB1, 8'h20, 4'h0};
        vecs[3] = '{1'b0, 4'h0, 2'd0, 2'd1, 2'd3, 8'h00, 8'h01, 8'hFF, 8'h02, 4'h0};
        vecs[4] = '{1'b0, 4'h0, 2'd2, 2'd2, 2'd2, 8'h00, 8'hA2, 8'hD1, 8'hD1, 4'h0};
        vecs[5] = '{1'b0, 4'h1, 2'd2, 2'd3, 2'd0, 8'h00, 8'hA1, 8'hA2, 8'h01, 4'h1};
        vecs[6] = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'hA2, 8'h01, 4'h1};
        vecs[7] = '{1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 8'h01, 8'h01, 8'hA2, 8'h01, 4'h1};
        vecs[8] = '{1'b0, 4'h1, 2'd0, 2'd1, 2'd3, 8'h00, 8'hFF, 8'h00, 8'h01, 4'h1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 4'h0;
        cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_rd = 2'd0; cmd_imm = 8'h00; rd_addr = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(res_data), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);

        // Back-to-back loads: one per cycle, done on consecutive cycles
        cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = 2'd0; cmd_imm = 8'hB1;
        @(negedge clk);
        chk("b2b_done0", 32'(done), 32'd1);
        chk("b2b_res0", 32'(res_data), 32'hB1);
        cmd_rd = 2'd1; cmd_imm = 8'h20;
        @(negedge clk);
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_res1", 32'(res_data), 32'h20);
        cmd_valid = 1'b0;
        rd_addr = 2'd0; #1;
        chk("b2b_r0", 32'(rd_data), 32'hB1);
        rd_addr = 2'd1; #1;
        chk("b2b_r1", 32'(rd_data), 32'h20);
        @(negedge clk);
        chk("b2b_done_off", 32'(done), 32'd0);

        // Table: ops, wrap, self-update, loads leaving issue regs alone
        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Reset during EXEC: no writeback, no done, everything cleared
        @(negedge clk);
        cmd_ld = 1'b0; cmd_op = 4'h1; cmd_ra = 2'd3; cmd_rb = 2'd1; cmd_rd = 2'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_exec_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0; #1;
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sel", 32'(alu_sel), 32'd0);
        chk("mid_rst_a", 32'(alu_a), 32'd0);
        chk("mid_rst_res", 32'(res_data), 32'd0);
        for (int r = 0; r < 4; r++) begin
            rd_addr = 2'(r); #1;
            chk("mid_rst_reg", 32'(rd_data), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) bad_done++;
        end
        chk("post_rst_no_done", 32'(bad_done), 32'd0);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        rd_addr = 2'd2; #1;
        chk("post_rst_r2", 32'(rd_data), 32'd0);

        // Sweep sel 0..F with cmd_valid held high
        run_cmd('{1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h03, 8'h03, 8'h00, 8'h00, 4'h0});
        run_cmd('{1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 8'h05, 8'h05, 8'h00, 8'h00, 4'h0});
        @(negedge clk);
        cmd_ld = 1'b0; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd2; cmd_op = 4'h0;
        cmd_valid = 1'b1;
        k = 0; dn = 0;
        for (int c = 0; c < 150 && dn < 16; c++) begin
            hs = cmd_valid && cmd_ready;
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                chk("sweep_res", 32'(res_data), 32'(alu_fn(8'h03, 8'h05, 4'(dn))));
                dn++;
            end
            if (hs) begin
                chk("sweep_sel", 32'(alu_sel), 32'(k));
                k++;
                if (k == 16) cmd_valid = 1'b0;
                else         cmd_op = 4'(k);
            end
        end
        chk("sweep_accepts", 32'(k), 32'd16);
        chk("sweep_dones", 32'(dn), 32'd16);
        @(negedge clk);
        chk("sweep_idle_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
